// File: rtl/firebird7_in_gate2_ijtag_tdr_driver_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// firebird7_in_gate2_ijtag_tdr_driver_pkg : CSU state encoding, TDR length bounds
// Revision: 1.0
// ----------------------------------------------------------------------------
package firebird7_in_gate2_ijtag_tdr_driver_pkg;

  localparam int TDR_LEN_MIN = 1;
  localparam int TDR_LEN_MAX = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_DONE    = 3'd4
  } csu_state_t;

endpackage
`default_nettype wire

// File: rtl/firebird7_in_gate2_ijtag_tdr_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// firebird7_in_gate2_ijtag_tdr_driver : one capture-shift-update per request on a gate2 TDR
// Revision: 1.0
// ----------------------------------------------------------------------------
module firebird7_in_gate2_ijtag_tdr_driver
  import firebird7_in_gate2_ijtag_tdr_driver_pkg::*;
#(
  parameter int TDR_LEN = 8
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TDR_LEN-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [TDR_LEN-1:0] rsp_rdata,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  localparam int               CNT_W    = $clog2(TDR_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TDR_LEN - 1);

  if (TDR_LEN < TDR_LEN_MIN || TDR_LEN > TDR_LEN_MAX) begin : g_len_check
    $error("TDR_LEN out of range");
  end

  csu_state_t         state;
  csu_state_t         state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [TDR_LEN-1:0] wreg;
  logic [TDR_LEN-1:0] rreg;
  logic [TDR_LEN:0]   wreg_ext;
  logic [TDR_LEN:0]   rreg_ext;

  // Widened views keep the shift expressions legal for a 1-bit TDR.
  assign wreg_ext = {1'b0, wreg};
  assign rreg_ext = {ijtag_so, rreg};

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      wreg      <= '0;
      rreg      <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wreg <= req_wdata;
          end
        end
        ST_CAPTURE: begin
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          wreg    <= wreg_ext[TDR_LEN:1];
          rreg    <= rreg_ext[TDR_LEN:1];
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        ST_UPDATE: begin
          rsp_rdata <= rreg;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ijtag_sel = 1'b0;
    ijtag_ce  = 1'b0;
    ijtag_se  = 1'b0;
    ijtag_ue  = 1'b0;
    ijtag_si  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        ijtag_sel = 1'b1;
        ijtag_ce  = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        ijtag_sel = 1'b1;
        ijtag_se  = 1'b1;
        ijtag_si  = wreg[0];
        if (bit_cnt == LAST_BIT) begin
          state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        ijtag_sel = 1'b1;
        ijtag_ue  = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_firebird7_in_gate2_ijtag_tdr_driver.sv
`default_nettype none
// Scoreboard bench: 8-bit loopback TDR target and a 1-bit sri-style target (captures 0, data-out resets to 1).
module tb_firebird7_in_gate2_ijtag_tdr_driver;

  logic tck = 1'b0;
  logic rst = 1'b1;
  always #5 tck = ~tck;

  int unsigned ecnt = 0;
  always @(posedge tck) ecnt <= ecnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  typedef struct {
    logic [7:0]  rdata;
    logic [7:0]  wdata;
    int unsigned edge_no;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  // 8-bit DUT and loopback target
  logic       rv8 = 1'b0, rr8, rsv8, sel8, ce8, se8, ue8, si8;
  logic       so8 = 1'b0;
  logic [7:0] wd8 = 8'h00, rd8;
  logic [7:0] cap8 = 8'h00, tsr8 = 8'h00, tdout8 = 8'h00;

  firebird7_in_gate2_ijtag_tdr_driver #(.TDR_LEN(8)) u_dut8 (
    .ijtag_tck(tck), .ijtag_reset(rst),
    .req_valid(rv8), .req_ready(rr8), .req_wdata(wd8),
    .rsp_valid(rsv8), .rsp_rdata(rd8),
    .ijtag_sel(sel8), .ijtag_ce(ce8), .ijtag_se(se8), .ijtag_ue(ue8),
    .ijtag_si(si8), .ijtag_so(so8)
  );

  always @(posedge tck) begin
    if (sel8 & ce8)      tsr8 <= cap8;
    else if (sel8 & se8) tsr8 <= {si8, tsr8[7:1]};
  end
  always @(negedge tck) begin
    so8 <= tsr8[0];
    if (sel8 & ue8) tdout8 <= tsr8;
  end

  // 1-bit DUT and sri-style target
  logic       rv1 = 1'b0, rr1, rsv1, sel1, ce1, se1, ue1, si1;
  logic       so1 = 1'b0;
  logic [0:0] wd1 = 1'b0, rd1;
  logic       tsr1 = 1'b0, tdout1 = 1'b1;

  firebird7_in_gate2_ijtag_tdr_driver #(.TDR_LEN(1)) u_dut1 (
    .ijtag_tck(tck), .ijtag_reset(rst),
    .req_valid(rv1), .req_ready(rr1), .req_wdata(wd1),
    .rsp_valid(rsv1), .rsp_rdata(rd1),
    .ijtag_sel(sel1), .ijtag_ce(ce1), .ijtag_se(se1), .ijtag_ue(ue1),
    .ijtag_si(si1), .ijtag_so(so1)
  );

  always @(posedge tck) begin
    if (sel1 & ce1)      tsr1 <= 1'b0;
    else if (sel1 & se1) tsr1 <= si1;
  end
  always @(negedge tck) begin
    so1 <= tsr1;
    if (sel1 & ue1) tdout1 <= tsr1;
  end

  // Monitors: protocol rules every cycle, scoreboard pop on each response
  int         n_acc8 = 0, n_rsp8 = 0, n_acc1 = 0, n_rsp1 = 0;
  logic [7:0] si_v8 = 8'h00;
  int         si_n8 = 0;
  logic       si_v1 = 1'b0;
  int         si_n1 = 0;

  always @(negedge tck) begin
    exp_t e;
    chk("ctl_onehot8", 32'($onehot0({ce8, se8, ue8})), 32'd1);
    chk("ctl_nosel8", 32'((ce8 | se8 | ue8) & ~sel8), 32'd0);
    if (rr8) chk("idle_ctl8", 32'({sel8, ce8, se8, ue8, si8, rsv8}), 32'd0);
    if (ce8) begin si_v8 = 8'h00; si_n8 = 0; end
    if (se8) begin si_v8 = {si8, si_v8[7:1]}; si_n8++; end
    if (rsv8) begin
      n_rsp8++;
      if (q8.size() == 0) begin
        chk("rsp_unexpected8", 32'(rsv8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("rdata8", 32'(rd8), 32'(e.rdata));
        chk("rsp_edge8", ecnt, e.edge_no);
        chk("tgt_dout8", 32'(tdout8), 32'(e.wdata));
        chk("si_seq8", 32'(si_v8), 32'(e.wdata));
        chk("shift_len8", 32'(si_n8), 32'd8);
      end
    end
  end

  always @(negedge tck) begin
    exp_t e;
    chk("ctl_onehot1", 32'($onehot0({ce1, se1, ue1})), 32'd1);
    chk("ctl_nosel1", 32'((ce1 | se1 | ue1) & ~sel1), 32'd0);
    if (rr1) chk("idle_ctl1", 32'({sel1, ce1, se1, ue1, si1, rsv1}), 32'd0);
    if (ce1) begin si_v1 = 1'b0; si_n1 = 0; end
    if (se1) begin si_v1 = si1; si_n1++; end
    if (rsv1) begin
      n_rsp1++;
      if (q1.size() == 0) begin
        chk("rsp_unexpected1", 32'(rsv1), 32'd0);
      end else begin
        e = q1.pop_front();
        chk("rdata1", 32'(rd1), 32'(e.rdata));
        chk("rsp_edge1", ecnt, e.edge_no);
        chk("tgt_dout1", 32'(tdout1), 32'(e.wdata));
        chk("si_seq1", 32'(si_v1), 32'(e.wdata));
        chk("shift_len1", 32'(si_n1), 32'd1);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge just before the accepting rising edge.
  task automatic send8(input logic [7:0] wd, input logic [7:0] cap, input bit expect_rsp,
                       output int unsigned acc);
    bit got = 1'b0;
    wd8 = wd;
    rv8 = 1'b1;
    for (int t = 0; t < 64 && !got; t++) begin
      if (rr8) got = 1'b1;
      else @(negedge tck);
    end
    chk("accept_timeout8", 32'(got), 32'd1);
    cap8 = cap;
    acc  = ecnt;
    if (got && expect_rsp) begin
      n_acc8++;
      q8.push_back('{rdata: cap, wdata: wd, edge_no: ecnt + 11});
    end
  endtask

  task automatic send1(input logic [0:0] wd, output int unsigned acc);
    bit got = 1'b0;
    wd1 = wd;
    rv1 = 1'b1;
    for (int t = 0; t < 64 && !got; t++) begin
      if (rr1) got = 1'b1;
      else @(negedge tck);
    end
    chk("accept_timeout1", 32'(got), 32'd1);
    acc = ecnt;
    if (got) begin
      n_acc1++;
      q1.push_back('{rdata: 8'h00, wdata: {7'd0, wd}, edge_no: ecnt + 4});
    end
  endtask

  task automatic wait_idle8();
    bit done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge tck);
      if (rr8 && q8.size() == 0) done = 1'b1;
    end
    chk("drain_timeout8", 32'(done), 32'd1);
  endtask

  task automatic wait_idle1();
    bit done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge tck);
      if (rr1 && q1.size() == 0) done = 1'b1;
    end
    chk("drain_timeout1", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned a1, a2;
    logic [7:0]  dsave;

    rst = 1'b1;
    repeat (3) @(negedge tck);
    rst = 1'b0;

    // Idle after reset
    repeat (5) begin
      @(negedge tck);
      chk("idle_ready8", 32'(rr8), 32'd1);
      chk("idle_ready1", 32'(rr1), 32'd1);
      chk("idle_rdata8", 32'(rd8), 32'd0);
      chk("idle_rdata1", 32'(rd1), 32'd0);
    end

    // 1-bit sri target: data-out 1 -> 0
    chk("sri_dout_init", 32'(tdout1), 32'd1);
    send1(1'b0, a1);
    @(negedge tck);
    rv1 = 1'b0;
    wait_idle1();
    chk("sri_dout_upd", 32'(tdout1), 32'd0);

    // Loopback target, several patterns
    send8(8'h3C, 8'hA5, 1'b1, a1);
    @(negedge tck);
    rv8 = 1'b0;
    wait_idle8();
    send8(8'h01, 8'h80, 1'b1, a1);
    @(negedge tck);
    rv8 = 1'b0;
    wait_idle8();
    send8(8'hFF, 8'h00, 1'b1, a1);
    @(negedge tck);
    rv8 = 1'b0;
    wait_idle8();

    // Back-to-back with valid held high
    send8(8'h96, 8'h69, 1'b1, a1);
    @(negedge tck);
    send8(8'h0F, 8'hF0, 1'b1, a2);
    chk("b2b_spacing", a2 - a1, 32'd12);
    @(negedge tck);
    rv8 = 1'b0;
    wait_idle8();

    // Reset during SHIFT cycle 4 aborts the CSU
    dsave = tdout8;
    send8(8'hAA, 8'h55, 1'b0, a1);
    @(negedge tck);
    rv8 = 1'b0;
    repeat (4) @(negedge tck);
    chk("abort_in_shift", 32'(se8), 32'd1);
    rst = 1'b1;
    @(negedge tck);
    chk("abort_ctl", 32'({sel8, ce8, se8, ue8, si8, rsv8}), 32'd0);
    chk("abort_ready", 32'(rr8), 32'd1);
    chk("abort_rdata", 32'(rd8), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge tck);
    chk("abort_dout", 32'(tdout8), 32'(dsave));

    send8(8'h5A, 8'hC3, 1'b1, a1);
    @(negedge tck);
    rv8 = 1'b0;
    wait_idle8();

    // Valid toggled while busy is ignored
    send8(8'h24, 8'h81, 1'b1, a1);
    for (int i = 0; i < 8; i++) begin
      @(negedge tck);
      rv8 = (i % 2) == 1;
    end
    @(negedge tck);
    rv8 = 1'b0;
    wait_idle8();
    repeat (4) @(negedge tck);

    chk("rsp_count8", 32'(n_rsp8), 32'(n_acc8));
    chk("rsp_count1", 32'(n_rsp1), 32'(n_acc1));
    chk("queue_left8", 32'(q8.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/firebird7_in_gate2_ijtag_tdr_driver.md
# firebird7_in_gate2_ijtag_tdr_driver

IJTAG initiator that runs one complete capture-shift-update (CSU) sequence on a single downstream TDR per request. It drives the sel/ce/se/ue/si side of the gate2 IJTAG network and collects the retimed scan-out. It sits between an on-chip test/debug agent (simple valid/ready request, single-cycle response) and a `firebird7_in_gate2_tessent_tdr_*` target. The block makes TDR access possible without an external TAP sequencer.

## Interface
- `TDR_LEN`, 8: target TDR length in bits, legal range 1..32; sets the shift count and data widths.
- `ijtag_tck` input 1: single clock; every register in the block is on its rising edge.
- `ijtag_reset` input 1: reset, synchronous, active-high. This block does not drive the targets' own reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block idle and able to accept.
- `req_wdata` input TDR_LEN: value to be shifted in and applied at update. Bit 0 is shifted first.
- `rsp_valid` output 1: one-cycle pulse, CSU complete.
- `rsp_rdata` output TDR_LEN: captured TDR contents. Bit 0 is the first bit out. Held until the next response.
- `ijtag_sel` output 1: target select.
- `ijtag_ce` output 1: capture enable.
- `ijtag_se` output 1: shift enable.
- `ijtag_ue` output 1: update enable.
- `ijtag_si` output 1: scan data to target.
- `ijtag_so` input 1: scan data from target, already retimed on the target's low phase.

## Operation
- Handshake:
  - A request is accepted on an edge where `req_valid & req_ready` is true.
  - `req_wdata` is latched into the write shift register on that edge.
  - No `rsp_ready` signal exists; the consumer must take `rsp_rdata` when `rsp_valid` pulses.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
  - IDLE: `req_ready`=1; all IJTAG controls 0; `ijtag_si`=0. On accept → CAPTURE.
  - CAPTURE: lasts 1 cycle; `sel`=1, `ce`=1. → SHIFT, bit counter cleared to 0.
  - SHIFT: lasts exactly TDR_LEN cycles; `sel`=1, `se`=1, `ijtag_si` = wreg[0]. On each edge:
    - wreg shifts right, with 0 filled in.
    - rreg <= {ijtag_so, rreg[TDR_LEN-1:1]}.
    - Counter increments.
    - When counter reaches TDR_LEN-1 → UPDATE.
  - UPDATE: lasts 1 cycle; `sel`=1, `ue`=1. The target latches its data-out on the falling edge within this cycle. → DONE.
  - DONE: lasts 1 cycle; `rsp_valid`=1; `rsp_rdata` <= rreg is loaded on entry. `req_ready`=0. → IDLE.
- Control signals are one-hot-or-zero:
  - `ce`, `se` and `ue` are never high together.
  - None of them is high without `sel`.
- Counter width is clog2(TDR_LEN)+1. For TDR_LEN=1, SHIFT lasts exactly one cycle.
- `req_valid` while busy is ignored. The request is held by the requester, not queued.
- Reset:
  - Takes effect on an edge with `ijtag_reset`=1 and overrides every state, including mid-SHIFT or mid-UPDATE.
  - Returns the FSM to IDLE and clears wreg, rreg, counter and `rsp_rdata` to 0.
  - An aborted CSU produces no `rsp_valid`.
  - If reset lands before UPDATE, the target's data-out is not updated.

## Timing
- Reset values of outputs: `req_ready`=1; every other output is 0, including `rsp_rdata`.
- All outputs are registered or decoded from the registered state only. There is no combinational path from `req_valid` or `ijtag_so` to any output.
- Cycle positions, with accept at edge 0:
  - CAPTURE: cycle 1.
  - SHIFT: cycles 2..TDR_LEN+1.
  - UPDATE: cycle TDR_LEN+2.
  - `rsp_valid`: cycle TDR_LEN+3.
  - `req_ready` returns at cycle TDR_LEN+4.
- Throughput: one CSU per TDR_LEN+4 cycles.
- `ijtag_so` is sampled on the rising edge that ends each SHIFT cycle. It is valid there because the target retimes it on the low phase.

## Structure
- A shared package/include holds:
  - the state encoding constants (3-bit, binary);
  - the TDR_LEN legality bounds (1, 32).
- Single flat module with no sub-module. The FSM, counter and two shift registers are tightly coupled.

## Test plan
- Reset, then idle for 5 cycles → `req_ready`=1; sel/ce/se/ue/si=0; `rsp_valid` never asserted.
- TDR_LEN=1, target from the sri_tdr family (captures 0, resets data-out to 1), `req_wdata`=0 → `rsp_valid` at cycle 4 with `rsp_rdata`=0; target data-out goes 1→0 at the UPDATE falling edge.
- TDR_LEN=8, loopback target model capturing 8'hA5, `req_wdata`=8'h3C:
  - `rsp_rdata`=8'hA5 at cycle 11;
  - `ijtag_si` sequence 0,0,1,1,1,1,0,0 across cycles 2..9;
  - target data-out = 8'h3C after UPDATE.
- Two back-to-back requests with `req_valid` held high → second accept exactly at cycle TDR_LEN+4; no overlap of sel phases.
- `ijtag_reset` pulsed during SHIFT cycle 4 (TDR_LEN=8) → all controls 0 on the next edge; no `rsp_valid`; target data-out unchanged; a new request afterwards completes normally.
- `req_valid` toggled while busy → ignored; exactly one response per accepted request.
